// File: rtl/ext_arbiter_pkg.sv
// ext_arbiter_pkg: shared constants and types for the immediate-extender arbiter.
//   IMM_W / DATA_W : immediate and result widths
//   EOP_*          : extend-op encodings
//   state_t        : result-register occupancy state
package ext_arbiter_pkg;

   localparam int unsigned N_REQ  = 2;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] EOP_SIGN     = 2'd0;
   localparam logic [1:0] EOP_ZERO     = 2'd1;
   localparam logic [1:0] EOP_LUI      = 2'd2;
   localparam logic [1:0] EOP_SIGN_SL2 = 2'd3;

   typedef enum logic {
      st_empty,
      st_full
   } state_t;

endpackage

// File: rtl/ext_arbiter_if.sv
// ext_arbiter_if: request/result bundle between two requesters, the arbiter and the consumer.
//   req_valid[i]      : requester i presents a request
//   req_imm0/req_eop0 : requester 0 immediate and extend op
//   req_imm1/req_eop1 : requester 1 immediate and extend op
//   req_ready[i]      : requester i accepted this cycle
//   out_valid/out_data/out_id : registered result and owning requester
//   out_ready         : consumer takes the result this cycle
// Modports: slave = arbiter side, master = requester/consumer side.
interface ext_arbiter_if;
   import ext_arbiter_pkg::*;

   logic [1:0]        req_valid;
   logic [IMM_W-1:0]  req_imm0;
   logic [1:0]        req_eop0;
   logic [IMM_W-1:0]  req_imm1;
   logic [1:0]        req_eop1;
   logic [1:0]        req_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_id;
   logic              out_ready;

   modport slave (
      input  req_valid, req_imm0, req_eop0, req_imm1, req_eop1, out_ready,
      output req_ready, out_valid, out_data, out_id
   );

   modport master (
      output req_valid, req_imm0, req_eop0, req_imm1, req_eop1, out_ready,
      input  req_ready, out_valid, out_data, out_id
   );

endinterface

// File: rtl/ext_arbiter_ext.sv
// ext: combinational immediate extender.
//   imm : IMM_W-bit immediate
//   EOp : extend op (sign / zero / upper / sign-shift-left-2)
//   ext : DATA_W-bit extended result
module ext
   import ext_arbiter_pkg::*;
(
   input  logic [IMM_W-1:0]  imm,
   input  logic [1:0]        EOp,
   output logic [DATA_W-1:0] ext
);

   always_comb begin
      ext = '0;
      unique case (EOp)
         EOP_SIGN:     ext = {{16{imm[15]}}, imm};
         EOP_ZERO:     ext = {16'h0000, imm};
         EOP_LUI:      ext = {imm, 16'h0000};
         EOP_SIGN_SL2: ext = {{14{imm[15]}}, imm, 2'b00};
         default:      ext = '0;
      endcase
   end

endmodule

// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin arbiter sharing one immediate extender between two requesters,
// with a registered valid/ready result tagged by the owning requester.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : ext_arbiter_if.slave (requests in, req_ready / result out)
// Optional build macro EXT_ARB_STATS_EN adds grant_cnt0, grant_cnt1 and stall_cnt counters.
module ext_arbiter
   import ext_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   ext_arbiter_if.slave       bus
`ifdef EXT_ARB_STATS_EN
   ,
   output logic [31:0]        grant_cnt0,
   output logic [31:0]        grant_cnt1,
   output logic [31:0]        stall_cnt
`endif
);

   state_t            state_q, state_d;
   logic              last_q;
   logic [DATA_W-1:0] data_q;
   logic              id_q;
   logic              can_accept;
   logic [1:0]        grant;
   logic              win;
   logic [IMM_W-1:0]  win_imm;
   logic [1:0]        win_eop;
   logic [DATA_W-1:0] ext_val;

   // A full register may still accept when the consumer drains it in the same cycle.
   always_comb begin
      grant      = 2'b00;
      state_d    = state_q;
      can_accept = (state_q == st_empty) || bus.out_ready;
      if (!reset && can_accept) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // last_q == 1 means requester 1 won last, so requester 0 goes next.
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
      if (grant != 2'b00) begin
         state_d = st_full;
      end else if ((state_q == st_full) && bus.out_ready) begin
         state_d = st_empty;
      end
   end

   assign win     = grant[1];
   assign win_imm = win ? bus.req_imm1 : bus.req_imm0;
   assign win_eop = win ? bus.req_eop1 : bus.req_eop0;

   ext u_ext (
      .imm (win_imm),
      .EOp (win_eop),
      .ext (ext_val)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= st_empty;
         last_q  <= 1'b1;
         data_q  <= '0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant != 2'b00) begin
            data_q <= ext_val;
            id_q   <= win;
            last_q <= win;
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.out_valid = (state_q == st_full);
   assign bus.out_data  = data_q;
   assign bus.out_id    = id_q;

`ifdef EXT_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt  <= '0;
      end else begin
         if (grant[0]) grant_cnt0 <= grant_cnt0 + 32'd1;
         if (grant[1]) grant_cnt1 <= grant_cnt1 + 32'd1;
         if ((bus.req_valid != 2'b00) && (grant == 2'b00)) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
